// File: rtl/ssp_frame_tx_pkg.sv
// Shared definitions for the SSP frame transmitter: parameter defaults and FSM encoding.
package ssp_frame_tx_pkg;

  localparam int DIV_DEF   = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/ssp_frame_tx_clkdiv.sv
// Half-period divider: counts 0..DIV-1 while enabled, pulses wrap on DIV-1, toggles clk_o on wrap.
// Single-cycle wrap pulse; clear forces count and clock low with priority over enable.
module ssp_clkdiv #(
  parameter int DIV = 4,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          tog_en_i,
  output logic          wrap_o,
  output logic [CW-1:0] cnt_o,
  output logic          clk_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;

  assign wrap_o = en_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (clr_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      // Counting continues in the gap with the clock held low.
      if (wrap_o && tog_en_i) clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign cnt_o = cnt_q;
  assign clk_o = clk_q;

endmodule

// File: rtl/ssp_frame_tx.sv
// Serialises one byte MSB-first onto ssp_clk/ssp_frame/ssp_bit with a router select; all outputs registered.
// Accepts a byte only when idle (din_ready); a frame plus gap occupies (2*WIDTH+2)*DIV cycles.
module ssp_frame_tx
  import ssp_frame_tx_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             ck_1356meg,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_ch,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_bit,
  output logic             sel,
  output logic             busy
);

  localparam int CW     = $clog2(DIV);
  localparam int HALVES = 2 * WIDTH + 2;
  localparam int HW     = $clog2(HALVES);

  state_e           state_q, state_d;
  logic [HW-1:0]    half_q, half_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sel_q, sel_d;
  logic             frame_q, frame_d;
  logic             rdy_q, busy_q;
  logic             wrap, fall, capture;
  logic [CW-1:0]    cnt;

  assign capture = (state_q == IDLE) && din_valid && rdy_q;
  // Odd half-period count before a wrap means this wrap is a falling toggle.
  assign fall    = wrap && half_q[0];

  ssp_clkdiv #(
    .DIV (DIV),
    .CW  (CW)
  ) u_clkdiv (
    .clk_i    (ck_1356meg),
    .rst_i    (reset),
    .en_i     (state_q != IDLE),
    .clr_i    (state_q == IDLE),
    .tog_en_i (state_q == SHIFT),
    .wrap_o   (wrap),
    .cnt_o    (cnt),
    .clk_o    (ssp_clk)
  );

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    if (wrap) half_d = half_q + 1'b1;
    // Zero fill means the final shift leaves ssp_bit low through gap and idle.
    if (fall) begin
      shreg_d = shreg_q << 1;
      frame_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SHIFT;
          half_d  = '0;
          shreg_d = din;
          sel_d   = din_ch;
          frame_d = 1'b1;
        end
      end
      SHIFT: begin
        if (fall && half_q == HW'(2 * WIDTH - 1)) state_d = GAP;
      end
      GAP: begin
        // Leave one cycle early so din_ready is up for a capture on the gap's last edge.
        if (half_q == HW'(HALVES - 1) && cnt == CW'(DIV - 2)) begin
          state_d = IDLE;
          half_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      shreg_q <= '0;
      sel_q   <= 1'b0;
      frame_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      rdy_q   <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign din_ready = rdy_q;
  assign ssp_frame = frame_q;
  assign ssp_bit   = shreg_q[WIDTH-1];
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule

// File: doc/ssp_frame_tx.md
SSP_FRAME_TX -- requirements
Module: ssp_frame_tx

Interface
REQ-001 SHALL have parameter DIV, default 4: ssp_clk half-period in ck_1356meg cycles; legal range 2..255.
REQ-002 SHALL have parameter WIDTH, default 8: bits per frame.
REQ-003 ck_1356meg  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  byte to transmit.
REQ-006 din_ch  input  1  destination channel for this byte; drives the downstream two-way router select.
REQ-007 din_valid  input  1  din/din_ch valid.
REQ-008 din_ready  output  1  block can accept a byte this cycle.
REQ-009 ssp_clk  output  1  serial bit clock to the ARM.
REQ-010 ssp_frame  output  1  frame marker, high for the first bit period.
REQ-011 ssp_bit  output  1  serial data; feeds the router data input.
REQ-012 sel  output  1  router select, stable for a whole frame.
REQ-013 busy  output  1  frame in progress (state != IDLE).

Function
REQ-014 SHALL implement states IDLE, SHIFT, GAP; IDLE->SHIFT on capture, SHIFT->GAP after the last bit, GAP->IDLE after one ssp_clk period.
REQ-015 SHALL assert din_ready only in IDLE and out of reset; capture occurs on the edge where din_valid && din_ready.
REQ-016 On capture SHALL latch din into a shift register and din_ch into sel; din/din_ch changes afterwards SHALL have no effect on the current frame.
REQ-017 SHALL ignore din_valid whenever din_ready is low (no queuing, no capture).
REQ-018 Divider counter SHALL run 0..DIV-1 only in SHIFT and GAP, clear on capture, and toggle ssp_clk on each wrap (cnt==DIV-1).
REQ-019 ssp_clk SHALL be 0 in IDLE and from the cycle after capture; first rising edge DIV cycles after capture.
REQ-020 ssp_bit SHALL present din[WIDTH-1] from the cycle after capture, MSB first, advancing one bit on each ssp_clk falling toggle, so each bit is stable across one full ssp_clk rising edge.
REQ-021 ssp_frame SHALL be high from the cycle after capture until the first ssp_clk falling toggle (2*DIV cycles), low otherwise.
REQ-022 After the falling toggle ending bit 0, SHALL enter GAP with ssp_bit=0, ssp_clk=0 for 2*DIV cycles.
REQ-023 din_ready SHALL reassert exactly (2*WIDTH+2)*DIV cycles after the capture edge (72 for defaults); back-to-back frames thus separated by the GAP.
REQ-024 sel SHALL change only at capture, never mid-frame; holds last value in IDLE.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs except none (din_ready is from state only).

Reset
REQ-026 Reset asserted SHALL immediately force state IDLE, ssp_clk=0, ssp_frame=0, ssp_bit=0, sel=0, busy=0, din_ready=0, counters and shift register 0.
REQ-027 din_ready SHALL go high on the first clock edge after reset deasserts.
REQ-028 Reset mid-frame SHALL abort the frame; no partial frame resumes after release.

Structure
REQ-029 State encodings and DIV/WIDTH defaults SHALL live in a shared include header used by the top-level and the bench.
REQ-030 The divider SHALL be a sub-module ssp_clkdiv (enable, clear, wrap pulse, toggled clock output); the rest stays in ssp_frame_tx.

Verification
REQ-031 Defaults, din=0xA5, din_ch=1, one-cycle valid -> sel=1 next cycle; ssp_bit sampled at 8 ssp_clk rising edges reads 1,0,1,0,0,1,0,1; ssp_frame high exactly cycles 1..8 after capture.
REQ-032 Two bytes 0x3C (ch 0) then 0xFF (ch 1) with valid held high -> second captured exactly 72 cycles after first; sel 0 through frame 1, 1 through frame 2.
REQ-033 din_valid pulsed with 0x00 at cycle 20 of an active frame -> ignored; frame unchanged, no extra frame emitted.
REQ-034 Reset asserted at cycle 30 of a 0x81 frame -> all outputs 0 same cycle; din_ready high first edge after release; next byte 0x55 transmits cleanly.
REQ-035 DIV=2 -> ssp_clk period 4 cycles, din_ready reasserts 36 cycles after capture; DIV=255 -> 4590 cycles.
